uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter sharing one UART transmitter among NREQ byte-stream requesters. Sits between client logic and the transmitter's start/busy handshake, latches the winning requester's byte, launches it, and tracks completion. Supports bounded multi-byte bursts so a framed message goes out uninterrupted without starving other requesters.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAX_BURST, 16, max bytes per grant before forced release (1..255)
- BUSY_TIMEOUT, 15, cycles to wait for tx_busy to rise after tx_start (1..255)

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- req  input  NREQ  per-requester byte-valid; held with data/last until matching ack
- data  input  8*NREQ  requester i byte on data[8*i+7:8*i]
- last  input  NREQ  byte is final of burst
- gnt  output  NREQ  one-hot current owner; 0 when idle
- ack  output  NREQ  one-cycle pulse: requester's byte consumed
- tx_data  output  8  byte to transmitter, registered
- tx_start  output  1  one-cycle launch pulse
- tx_busy  input  1  transmitter frame in progress
- busy  output  1  arbiter not IDLE
- err  output  1  one-cycle pulse on busy timeout

## Operation
- State machine IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if any req, winner = first set bit scanning from ptr upward, wrapping modulo NREQ. Register gnt, tx_data, last bit of winner; burst count = 1; go SEND. If no req, stay.
- SEND (exactly 1 cycle): tx_start=1, ack[winner]=1; go WAIT_BUSY, timeout counter cleared.
- WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Counter increments each cycle; reaching BUSY_TIMEOUT with tx_busy still 0 -> err pulse, release, IDLE.
- WAIT_DONE: on tx_busy=0:
  - latched last=0, req[winner]=1, count < MAX_BURST -> latch next data/last of winner, count+1, SEND (gnt unchanged).
  - otherwise release -> IDLE.
- Release: gnt=0, ptr = (winner+1) mod NREQ. Applies on last byte, req dropped mid-burst, MAX_BURST reached, or timeout.
- Requesters not granted are ignored; their req changes have no effect until IDLE.
- ack always targets the requester in gnt; never more than one ack bit set.
- Burst count 8 bits; compare is count >= MAX_BURST forces release.

## Timing
- Reset values: gnt=0, ack=0, tx_data=0x00, tx_start=0, busy=0, err=0, ptr=0, state IDLE, counters 0.
- Reset assertion at any state aborts immediately; tx_start/ack cannot pulse during or in the cycle reset deasserts.
- Latency: req sampled high in IDLE at edge N -> gnt, tx_data, tx_start, ack all valid during cycle N+1.
- data/last sampled at IDLE->SEND and WAIT_DONE->SEND edges only.
- Burst byte-to-byte: tx_busy falls at edge M -> next tx_start during cycle M+1.
- Release to next grant: WAIT_DONE->IDLE at edge M, earliest new tx_start during M+2.
- busy = 1 in SEND, WAIT_BUSY, WAIT_DONE; 0 in IDLE.
- tx_busy high in the SEND cycle is ignored; only WAIT_BUSY samples the rise.
- Timeout: err pulses in cycle after the BUSY_TIMEOUT-th WAIT_BUSY cycle with tx_busy=0; arbiter in IDLE the same cycle as err.
- ptr update and gnt clear occur on the release edge; simultaneous new requests are evaluated against the updated ptr the following cycle.

## Test plan
- Single byte: reset, req[2]=1, data=0xA5, last=1 -> cycle later gnt=4'b0100, tx_data=0xA5, tx_start=1, ack[2]=1; model tx_busy 10 cycles -> IDLE, ptr=3.
- Round-robin fairness: req=4'b1111 constant, every byte last=1 -> grant order 0,1,2,3,0 each one byte; no requester granted twice consecutively.
- Burst: req[1] sends 0x10,0x11,0x12 with last on third while req[0] also high -> three consecutive tx_starts all gnt[1], then gnt[0].
- Burst cap: MAX_BURST=4, req[3] streams last=0 indefinitely, req[0] high -> exactly 4 bytes from 3, release, next grant 0.
- Timeout: tx_busy held 0 after tx_start -> err pulse after 15 WAIT_BUSY cycles, gnt=0, busy=0, next pending requester granted.
- Reset mid-burst: assert reset in WAIT_DONE -> all outputs 0 asynchronously; after release, req[3] and req[0] high -> gnt[0] first (ptr=0).

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter handshake bundle for the UART TX arbiter
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              busy;
  logic              err;

  modport master (
    output req, data, last, tx_busy,
    input  gnt, ack, tx_data, tx_start, busy, err
  );

  modport slave (
    input  req, data, last, tx_busy,
    output gnt, ack, tx_data, tx_start, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter, bounded bursts
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   win_q, win_d, ptr_q, ptr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      cnt_q, cnt_d, tmo_q, tmo_d;
  logic            last_q, last_d, err_q, err_d;

  logic [NREQ-1:0] req_rot;
  logic            rr_found;
  logic [IW-1:0]   rr_off, rr_idx, ptr_nx;
  logic [IW:0]     rr_sum;
  logic [7:0]      rr_byte, win_byte;
  logic            rr_last, win_last, win_req;

  // Rotate so bit 0 is the requester at ptr; lowest set bit is the winner.
  always_comb begin
    req_rot  = NREQ'({bus.req, bus.req} >> ptr_q);
    rr_found = 1'b0;
    rr_off   = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rr_found = 1'b1;
        rr_off   = IW'(i);
      end
    end
    rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
    rr_idx = (rr_sum >= NREQ_W) ? IW'(rr_sum - NREQ_W) : IW'(rr_sum);
    ptr_nx = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
  end

  always_comb begin
    rr_byte  = '0;
    rr_last  = 1'b0;
    win_byte = '0;
    win_last = 1'b0;
    win_req  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_idx == IW'(i)) begin
        rr_byte = bus.data[8*i +: 8];
        rr_last = bus.last[i];
      end
      if (win_q == IW'(i)) begin
        win_byte = bus.data[8*i +: 8];
        win_last = bus.last[i];
        win_req  = bus.req[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << rr_idx;
          win_d     = rr_idx;
          tx_data_d = rr_byte;
          last_d    = rr_last;
          cnt_d     = 8'd1;
          state_d   = SEND;
        end
      end
      SEND: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q + 8'd1 >= 8'(BUSY_TIMEOUT)) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          ptr_d   = ptr_nx;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (!last_q && win_req && (cnt_q < 8'(MAX_BURST))) begin
            tx_data_d = win_byte;
            last_d    = win_last;
            cnt_d     = cnt_q + 8'd1;
            state_d   = SEND;
          end else begin
            gnt_d   = '0;
            ptr_d   = ptr_nx;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      win_q     <= '0;
      ptr_q     <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = (state_q == SEND);
  assign bus.ack      = (state_q == SEND) ? gnt_q : '0;
  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = err_q;
endmodule
